// File: rtl/harris_frame_ctrl_if.sv
// Corner output channel of harris_frame_ctrl: ready/valid handshake carrying
// the window top-left coordinate of each detected corner.
interface harris_frame_ctrl_if #(
  parameter int CW = 10,
  parameter int RW = 9
);
  logic          corner_valid;
  logic          corner_ready;
  logic [CW-1:0] corner_x;
  logic [RW-1:0] corner_y;

  modport master (
    output corner_valid,
    output corner_x,
    output corner_y,
    input  corner_ready
  );

  modport slave (
    input  corner_valid,
    input  corner_x,
    input  corner_y,
    output corner_ready
  );
endinterface

// File: rtl/harris_frame_ctrl.sv
// Frame sequencer around the 10-cycle Harris score datapath: raster window counting,
// latency-matched coordinate delay line, strict signed thresholding and a corner FIFO.
// Optional corner statistics counter is enabled by defining HARRIS_CTRL_STATS_EN.
module harris_frame_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int LATENCY = 10,
  parameter int FIFO_D  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [127:0]   thresh,
  input  logic                  win_valid,
  input  logic signed [127:0]   score_in,
  harris_frame_ctrl_if.master   corner,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  protocol_err,
  output logic [31:0]           corner_count
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int NX  = IMG_W - 5;
  localparam int NY  = IMG_H - 5;
  localparam int AW  = $clog2(FIFO_D);
  localparam int FCW = $clog2(LATENCY + 1);

  localparam logic [CW-1:0]  X_LAST    = CW'(NX - 1);
  localparam logic [RW-1:0]  Y_LAST    = RW'(NY - 1);
  localparam logic [FCW-1:0] FLUSH_TOP = FCW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] x;
    logic [RW-1:0] y;
  } tap_t;

  state_t                state, state_n;
  logic                  start_ok;
  logic                  win_ok;
  logic                  last_win;
  logic [CW-1:0]         x_cnt;
  logic [RW-1:0]         y_cnt;
  logic [FCW-1:0]        flush_cnt;
  logic signed [127:0]   thresh_q;

  tap_t                  dline [LATENCY];
  tap_t                  tap;

  logic [CW+RW-1:0]      mem [FIFO_D];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    win_ok   = 1'b0;
    last_win = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (win_valid) begin
          win_ok = 1'b1;
          if (x_cnt == X_LAST && y_cnt == Y_LAST) begin
            last_win = 1'b1;
            state_n  = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      flush_cnt <= '0;
      thresh_q  <= '0;
    end else begin
      if (start_ok) begin
        x_cnt    <= '0;
        y_cnt    <= '0;
        thresh_q <= thresh;
      end else if (win_ok) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
      if (last_win) begin
        flush_cnt <= FLUSH_TOP;
      end else if (state == FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

  // The delay line keeps shifting in every state so frame tails keep pairing with their scores.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        dline[i] <= '0;
      end
    end else begin
      dline[0] <= {win_ok, x_cnt, y_cnt};
      for (int i = 1; i < LATENCY; i++) begin
        dline[i] <= dline[i-1];
      end
    end
  end

  assign tap      = dline[LATENCY-1];
  assign push_req = tap.v && (score_in > thresh_q);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && corner.corner_ready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // Storage is cleared on reset so the head coordinate reads 0 while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= {tap.x, tap.y};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign corner.corner_valid            = !fifo_empty;
  assign {corner.corner_x, corner.corner_y} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (start_ok) begin
        overflow <= 1'b0;
      end
      if (win_valid && state != RUN) begin
        protocol_err <= 1'b1;
      end else if (start_ok) begin
        protocol_err <= 1'b0;
      end
    end
  end

`ifdef HARRIS_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      corner_count <= '0;
    end else if (start_ok) begin
      corner_count <= '0;
    end else if (push_ok && corner_count != '1) begin
      corner_count <= corner_count + 1'b1;
    end
  end
`else
  assign corner_count = '0;
`endif

endmodule

// File: tb/tb_harris_frame_ctrl.sv
// Self-checking bench for harris_frame_ctrl on an 8x8 image (9 windows), LATENCY=10, FIFO_D=4.
// Drives frames from a vector table plus hand-written corner-case sequences; corners go through a scoreboard.
module tb_harris_frame_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int LAT   = 10;
  localparam int FD    = 4;
  localparam int NX    = IMG_W - 5;
  localparam int NWIN  = (IMG_W - 5) * (IMG_H - 5);
  localparam int NVEC  = 6;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } coord_t;

  typedef struct {
    logic signed [127:0] thr;
    logic signed [127:0] base;
    int                  sp_idx;
    logic signed [127:0] sp_score;
    int                  exp_n;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic signed [127:0] thresh;
  logic                win_valid;
  logic signed [127:0] score_in;
  logic signed [127:0] cur_score;
  logic                busy;
  logic                frame_done;
  logic                overflow;
  logic                protocol_err;
  logic [31:0]         corner_count;

  logic signed [127:0] pipe [LAT];
  logic signed [127:0] scores [NWIN];
  coord_t              exp_q [$];
  vec_t                vecs [NVEC];

  int n_pass   = 0;
  int n_total  = 0;
  int n_popped = 0;

  harris_frame_ctrl_if #(.CW(3), .RW(3)) cif ();

  harris_frame_ctrl #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .LATENCY (LAT),
    .FIFO_D  (FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .thresh       (thresh),
    .win_valid    (win_valid),
    .score_in     (score_in),
    .corner       (cif),
    .busy         (busy),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .protocol_err (protocol_err),
    .corner_count (corner_count)
  );

  always #5 clk = ~clk;

  // Model of the external fixed-latency score datapath.
  always @(posedge clk) begin
    pipe[0] <= cur_score;
    for (int i = 1; i < LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign score_in = pipe[LAT-1];

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && cif.corner_valid === 1'b1 && cif.corner_ready === 1'b1) begin
      check_output("sb_has_entry", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        coord_t e;
        e = exp_q.pop_front();
        check_output("corner_xy", {cif.corner_x, cif.corner_y}, {e.x, e.y});
      end
      n_popped++;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] stats_exp(input int n);
`ifdef HARRIS_CTRL_STATS_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  // One full frame: start, 9 back-to-back windows, then watch the flush/done sequence.
  task automatic apply_stimulus(input string tag, input logic signed [127:0] thr, input int keep,
                                input int ready_at, input bit restart_mid);
    int kept;
    int done_at;
    kept    = 0;
    done_at = -1;
    tick(1);
    start  = 1'b1;
    thresh = thr;
    tick(1);
    start = 1'b0;
    check_output({tag, "_busy_run"}, 128'(busy), 128'd1);
    check_output({tag, "_perr_clr"}, 128'(protocol_err), 128'd0);
    check_output({tag, "_ovf_clr"}, 128'(overflow), 128'd0);
    check_output({tag, "_cnt_clr"}, 128'(corner_count), 128'd0);
    for (int i = 0; i < NWIN; i++) begin
      if (i > 0) tick(1);
      win_valid = 1'b1;
      cur_score = scores[i];
      if (restart_mid && i == 2) begin
        start  = 1'b1;
        thresh = '0;
      end
      if (restart_mid && i == 3) start = 1'b0;
      if (scores[i] > thr && kept < keep) begin
        exp_q.push_back(coord_t'{x: 3'(i % NX), y: 3'(i / NX)});
        kept++;
      end
    end
    tick(1);
    win_valid = 1'b0;
    cur_score = '0;
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c > 0) tick(1);
      if (frame_done === 1'b1) done_at = (done_at < 0) ? c : 1000;
      if (c == ready_at) cif.corner_ready = 1'b1;
    end
    check_output({tag, "_done_at"}, 128'(done_at), 128'(LAT));
    check_output({tag, "_busy_idle"}, 128'(busy), 128'd0);
    check_output({tag, "_count"}, 128'(corner_count), 128'(stats_exp(kept)));
  endtask

  task automatic fill_scores(input logic signed [127:0] base, input int idx, input logic signed [127:0] sp);
    for (int i = 0; i < NWIN; i++) begin
      scores[i] = (i == idx) ? sp : base;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int popped0;
    reset            = 1'b1;
    start            = 1'b0;
    thresh           = '0;
    win_valid        = 1'b0;
    cur_score        = '0;
    cif.corner_ready = 1'b0;

    vecs[0] = '{thr: 128'sd100, base: 128'sd50, sp_idx: -1, sp_score: 128'sd0, exp_n: 0};
    vecs[1] = '{thr: 128'sd100, base: 128'sd50, sp_idx: 4, sp_score: 128'sd101, exp_n: 1};
    vecs[2] = '{thr: 128'sd100, base: 128'sd50, sp_idx: 4, sp_score: 128'sd100, exp_n: 0};
    vecs[3] = '{thr: -128'sd5, base: -128'sd10, sp_idx: 8, sp_score: -128'sd4, exp_n: 1};
    vecs[4] = '{thr: 128'sd0, base: 128'sd1, sp_idx: -1, sp_score: 128'sd0, exp_n: 9};
    vecs[5] = '{thr: 128'sd1 <<< 100, base: -(128'sd1 <<< 120), sp_idx: 0,
                sp_score: (128'sd1 <<< 100) + 128'sd1, exp_n: 1};

    tick(12);
    reset = 1'b0;
    check_output("rst_busy", 128'(busy), 128'd0);
    check_output("rst_done", 128'(frame_done), 128'd0);
    check_output("rst_ovf", 128'(overflow), 128'd0);
    check_output("rst_perr", 128'(protocol_err), 128'd0);
    check_output("rst_valid", 128'(cif.corner_valid), 128'd0);
    check_output("rst_xy", 128'({cif.corner_x, cif.corner_y}), 128'd0);
    check_output("rst_count", 128'(corner_count), 128'd0);

    cif.corner_ready = 1'b1;
    for (int v = 0; v < NVEC; v++) begin
      fill_scores(vecs[v].base, vecs[v].sp_idx, vecs[v].sp_score);
      popped0 = n_popped;
      apply_stimulus($sformatf("vec%0d", v), vecs[v].thr, 99, -1, 1'b0);
      tick(4);
      check_output($sformatf("vec%0d_ncorners", v), 128'(n_popped - popped0), 128'(vecs[v].exp_n));
      check_output($sformatf("vec%0d_sb_empty", v), 128'(exp_q.size()), 128'd0);
    end

    // win_valid while idle: flagged, never counted or pushed
    cur_score = 128'sd1 <<< 110;
    win_valid = 1'b1;
    tick(1);
    win_valid = 1'b0;
    cur_score = '0;
    check_output("perr_set", 128'(protocol_err), 128'd1);
    check_output("perr_busy", 128'(busy), 128'd0);
    tick(LAT + 3);
    check_output("perr_no_corner", 128'(cif.corner_valid), 128'd0);
    fill_scores(128'sd50, 0, 128'sd500);
    popped0 = n_popped;
    apply_stimulus("after_perr", 128'sd100, 99, -1, 1'b0);
    tick(4);
    check_output("after_perr_ncorners", 128'(n_popped - popped0), 128'd1);

    // start during RUN with a lower threshold must be ignored
    fill_scores(128'sd50, -1, 128'sd0);
    popped0 = n_popped;
    apply_stimulus("restart", 128'sd100, 99, -1, 1'b1);
    tick(4);
    check_output("restart_ncorners", 128'(n_popped - popped0), 128'd0);

    // overflow: consumer stalled, only first FD corners survive
    cif.corner_ready = 1'b0;
    fill_scores(128'sd200, -1, 128'sd0);
    apply_stimulus("ovf", 128'sd100, FD, -1, 1'b0);
    check_output("ovf_flag", 128'(overflow), 128'd1);
    check_output("ovf_valid", 128'(cif.corner_valid), 128'd1);
    popped0 = n_popped;
    cif.corner_ready = 1'b1;
    tick(8);
    check_output("ovf_drained", 128'(n_popped - popped0), 128'(FD));
    check_output("ovf_sb_empty", 128'(exp_q.size()), 128'd0);
    check_output("ovf_valid_low", 128'(cif.corner_valid), 128'd0);

    // full FIFO with a pop on the same edge as the next push: nothing dropped
    cif.corner_ready = 1'b0;
    fill_scores(128'sd50, -1, 128'sd0);
    for (int i = 0; i < 4; i++) scores[i] = 128'sd200;
    scores[8] = 128'sd200;
    popped0 = n_popped;
    apply_stimulus("fullpop", 128'sd100, 99, LAT - 1, 1'b0);
    check_output("fullpop_ovf", 128'(overflow), 128'd0);
    tick(8);
    check_output("fullpop_ncorners", 128'(n_popped - popped0), 128'd5);
    check_output("fullpop_sb_empty", 128'(exp_q.size()), 128'd0);

    // reset mid-RUN with two corners queued and two scores still in flight
    cif.corner_ready = 1'b0;
    tick(1);
    start  = 1'b1;
    thresh = 128'sd100;
    tick(1);
    start     = 1'b0;
    win_valid = 1'b1;
    cur_score = 128'sd200;
    tick(2);
    win_valid = 1'b0;
    cur_score = '0;
    tick(LAT + 2);
    check_output("rstmid_queued", 128'(cif.corner_valid), 128'd1);
    check_output("rstmid_busy_before", 128'(busy), 128'd1);
    win_valid = 1'b1;
    cur_score = 128'sd200;
    tick(2);
    win_valid = 1'b0;
    cur_score = '0;
    reset     = 1'b1;
    tick(1);
    reset = 1'b0;
    check_output("rstmid_busy", 128'(busy), 128'd0);
    check_output("rstmid_valid", 128'(cif.corner_valid), 128'd0);
    check_output("rstmid_xy", 128'({cif.corner_x, cif.corner_y}), 128'd0);
    popped0 = n_popped;
    cif.corner_ready = 1'b1;
    tick(LAT + 4);
    check_output("rstmid_no_push", 128'(n_popped - popped0), 128'd0);
    check_output("rstmid_count", 128'(corner_count), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
